// File: rtl/ad5791_serial_sequencer.sv
// Serial master for a bank of AD5791 DACs sharing SCLK/SYNC with one SDIN per DAC.
// Sends the control word after power-on, then streams 24-bit value frames from a one-deep shadow.
module ad5791_serial_sequencer #(
   parameter int          NUM_DAC   = 4,
   parameter int          CLK_DIV   = 4,
   parameter int          SYNC_GAP  = 4,
   parameter logic [23:0] INIT_WORD = 24'h200002,
   parameter int          POR_WAIT  = 64
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic [NUM_DAC*20-1:0]  s_axis_tdata,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   input  logic                   init_req,
   output logic                   PMD_clk,
   output logic                   PMD_sync,
   output logic [NUM_DAC-1:0]     PMD_dac,
   output logic                   init_done,
   output logic                   busy,
   output logic [15:0]            overrun_cnt
);

   localparam int DIV_W = $clog2(CLK_DIV) + 1;
   localparam int GAP_W = $clog2(SYNC_GAP) + 1;
   localparam int POR_W = $clog2(POR_WAIT) + 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SYNC_GAP - 1);
   localparam logic [POR_W-1:0] POR_LAST = POR_W'(POR_WAIT - 1);
   // The bit counter wraps from 0 to 31 on the last falling edge; that marks the final low phase.
   localparam logic [4:0] BIT_DONE = 5'd31;

   typedef enum logic [2:0] {POR, INIT_LOAD, IDLE, SETUP, SHIFT, GAP} state_t;

   state_t                state, state_next;
   logic [POR_W-1:0]      por_cnt;
   logic [DIV_W-1:0]      div_cnt;
   logic [GAP_W-1:0]      gap_cnt;
   logic [4:0]            bit_cnt;
   logic                  sclk_hi;
   logic [23:0]           frame [NUM_DAC];
   logic [NUM_DAC*20-1:0] shadow;
   logic                  pending;
   logic                  init_pend;
   logic                  frame_is_init;
   logic                  div_last;
   logic                  accept;
   logic                  init_go;
   logic                  load_data;
   logic                  sync_low;

   assign div_last  = (div_cnt == DIV_LAST);
   assign accept    = s_axis_tvalid && s_axis_tready;
   assign init_go   = init_pend || (init_req && init_done);
   assign load_data = (state == IDLE) && !init_go && pending;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state <= POR;
      else          state <= state_next;
   end

   always_comb begin
      state_next    = state;
      sync_low      = (state == SETUP) || (state == SHIFT);
      PMD_sync      = !sync_low;
      PMD_clk       = (state == SHIFT) && sclk_hi;
      busy          = (state != IDLE);
      s_axis_tready = init_done;
      PMD_dac       = '0;
      for (int k = 0; k < NUM_DAC; k++) begin
         if (sync_low && bit_cnt != BIT_DONE) PMD_dac[k] = frame[k][bit_cnt];
      end
      case (state)
         POR:       if (por_cnt == POR_LAST) state_next = INIT_LOAD;
         INIT_LOAD: state_next = SETUP;
         IDLE: begin
            if (init_go)      state_next = INIT_LOAD;
            else if (pending) state_next = SETUP;
         end
         SETUP:     if (div_last) state_next = SHIFT;
         SHIFT:     if (div_last && !sclk_hi && bit_cnt == BIT_DONE) state_next = GAP;
         GAP:       if (gap_cnt == GAP_LAST) state_next = IDLE;
         default:   state_next = POR;
      endcase
   end

   // Timing counters: SCLK half-period divider, bit position and inter-frame gap.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         por_cnt <= '0;
         div_cnt <= '0;
         gap_cnt <= '0;
         bit_cnt <= 5'd23;
         sclk_hi <= 1'b0;
      end else begin
         if (state == POR) por_cnt <= por_cnt + POR_W'(1);
         if (state == SETUP || state == SHIFT) div_cnt <= div_last ? '0 : div_cnt + DIV_W'(1);
         else                                  div_cnt <= '0;
         gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
         if (state == INIT_LOAD || load_data)           bit_cnt <= 5'd23;
         else if (state == SHIFT && div_last && sclk_hi) bit_cnt <= bit_cnt - 5'd1;
         case (state)
            SETUP:   sclk_hi <= div_last;
            SHIFT:   if (div_last) sclk_hi <= !sclk_hi;
            default: sclk_hi <= 1'b0;
         endcase
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int k = 0; k < NUM_DAC; k++) frame[k] <= '0;
         frame_is_init <= 1'b0;
         init_done     <= 1'b0;
         init_pend     <= 1'b0;
      end else begin
         if (state == INIT_LOAD) begin
            for (int k = 0; k < NUM_DAC; k++) frame[k] <= INIT_WORD;
            frame_is_init <= 1'b1;
         end else if (load_data) begin
            for (int k = 0; k < NUM_DAC; k++) frame[k] <= {4'b0001, shadow[20*k +: 20]};
            frame_is_init <= 1'b0;
         end
         if (state == SHIFT && state_next == GAP && frame_is_init) init_done <= 1'b1;
         // Requests before the first init completes are dropped: that init is already on its way.
         if (state == IDLE && init_go)  init_pend <= 1'b0;
         else if (init_req && init_done) init_pend <= 1'b1;
      end
   end

   // A word accepted while one is still waiting replaces it and counts as an overrun.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         shadow      <= '0;
         pending     <= 1'b0;
         overrun_cnt <= '0;
      end else begin
         if (accept) shadow <= s_axis_tdata;
         if (accept)         pending <= 1'b1;
         else if (load_data) pending <= 1'b0;
         if (accept && pending && !load_data && overrun_cnt != 16'hFFFF)
            overrun_cnt <= overrun_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_ad5791_serial_sequencer.sv
// Bench for ad5791_serial_sequencer: instance 0 (CLK_DIV=2) runs directed scenarios against a
// frame scoreboard, instance 1 (CLK_DIV=1) runs a streaming stress with latest-wins accounting.
module tb_ad5791_serial_sequencer;

   localparam logic [95:0] INIT4 = {4{24'h200002}};

   logic        aclk = 1'b0;
   logic        rstn [2];
   logic [79:0] tdata [2];
   logic        tvalid [2];
   logic        tready [2];
   logic        init_req [2];
   logic        sclk [2];
   logic        sync [2];
   logic [3:0]  dac [2];
   logic        done [2];
   logic        busy [2];
   logic [15:0] ovr [2];

   int n_tests = 0;
   int n_fail  = 0;

   logic [95:0] exp_q [$];
   logic [79:0] acc_q [$];

   logic        prev_clk [2];
   logic        prev_sync [2];
   logic [3:0]  prev_dac [2];
   logic [23:0] shreg [2][4];
   int          nbits [2]       = '{0, 0};
   int          low_len [2]     = '{0, 0};
   int          frames [2]      = '{0, 0};
   int          init_frames [2] = '{0, 0};
   int          data_frames [2] = '{0, 0};
   logic        viol [2]        = '{1'b0, 1'b0};
   logic [95:0] last_sent       = '0;

   always #5 aclk = ~aclk;

   ad5791_serial_sequencer #(.NUM_DAC(4), .CLK_DIV(2), .SYNC_GAP(4), .INIT_WORD(24'h200002), .POR_WAIT(64)) dut0 (
      .aclk(aclk), .aresetn(rstn[0]), .s_axis_tdata(tdata[0]), .s_axis_tvalid(tvalid[0]),
      .s_axis_tready(tready[0]), .init_req(init_req[0]), .PMD_clk(sclk[0]), .PMD_sync(sync[0]),
      .PMD_dac(dac[0]), .init_done(done[0]), .busy(busy[0]), .overrun_cnt(ovr[0]));

   ad5791_serial_sequencer #(.NUM_DAC(4), .CLK_DIV(1), .SYNC_GAP(2), .INIT_WORD(24'h200002), .POR_WAIT(8)) dut1 (
      .aclk(aclk), .aresetn(rstn[1]), .s_axis_tdata(tdata[1]), .s_axis_tvalid(tvalid[1]),
      .s_axis_tready(tready[1]), .init_req(init_req[1]), .PMD_clk(sclk[1]), .PMD_sync(sync[1]),
      .PMD_dac(dac[1]), .init_done(done[1]), .busy(busy[1]), .overrun_cnt(ovr[1]));

   task automatic checkOutput(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [95:0] mkFrame(input logic [79:0] v);
      logic [95:0] f;
      for (int k = 0; k < 4; k++) f[24*k +: 24] = {4'b0001, v[20*k +: 20]};
      return f;
   endfunction

   task automatic frameDone(input int i);
      logic [95:0] decoded;
      bit found;
      decoded = {shreg[i][3], shreg[i][2], shreg[i][1], shreg[i][0]};
      frames[i]++;
      checkOutput("sclk falling edges per frame", nbits[i], 24);
      checkOutput("sync low cycles", low_len[i], (i == 0) ? 98 : 49);
      if (i == 0) begin
         if (exp_q.size() == 0) checkOutput("frame expected", exp_q.size(), 1);
         else                   checkOutput("frame", decoded, exp_q.pop_front());
      end else if (decoded[23:20] == 4'b0010) begin
         init_frames[1]++;
         checkOutput("stress init frame", decoded, INIT4);
      end else begin
         found = 0;
         foreach (acc_q[j]) if (mkFrame(acc_q[j]) == decoded) found = 1;
         data_frames[1]++;
         last_sent = decoded;
         checkOutput("stress frame in accepted set", found, 1);
      end
   endtask

   // Decodes the serial lines: data is taken from the sample before each SCLK falling edge.
   initial begin
      forever begin
         @(negedge aclk);
         for (int i = 0; i < 2; i++) begin
            if (!rstn[i]) begin
               prev_clk[i]  = 1'b0;
               prev_sync[i] = 1'b1;
               prev_dac[i]  = '0;
               nbits[i]     = 0;
               low_len[i]   = 0;
            end else begin
               if (sync[i] && sclk[i]) viol[i] = 1'b1;
               if (prev_sync[i] && !sync[i]) begin
                  nbits[i]   = 0;
                  low_len[i] = 0;
               end
               if (!sync[i]) low_len[i]++;
               if (prev_clk[i] && !sclk[i]) begin
                  for (int k = 0; k < 4; k++) shreg[i][k] = {shreg[i][k][22:0], prev_dac[i][k]};
                  nbits[i]++;
               end
               if (!prev_sync[i] && sync[i]) frameDone(i);
               prev_clk[i]  = sclk[i];
               prev_sync[i] = sync[i];
               prev_dac[i]  = dac[i];
            end
         end
      end
   end

   task automatic applyStimulus(input int i, input logic [79:0] word, input bit push);
      @(negedge aclk);
      tdata[i]  = word;
      tvalid[i] = 1'b1;
      if (push) exp_q.push_back(mkFrame(word));
      @(posedge aclk);
      #1 tvalid[i] = 1'b0;
   endtask

   task automatic pulseInit(input int i);
      @(negedge aclk);
      init_req[i] = 1'b1;
      @(posedge aclk);
      #1 init_req[i] = 1'b0;
   endtask

   task automatic checkReset(input int i);
      checkOutput("reset PMD_clk", sclk[i], 0);
      checkOutput("reset PMD_sync", sync[i], 1);
      checkOutput("reset PMD_dac", dac[i], 0);
      checkOutput("reset init_done", done[i], 0);
      checkOutput("reset busy", busy[i], 1);
      checkOutput("reset tready", tready[i], 0);
      checkOutput("reset overrun_cnt", ovr[i], 0);
   endtask

   task automatic releaseAndCheckPor(input int i, input int exp_idx);
      int cyc = -1;
      @(negedge aclk);
      rstn[i] = 1'b1;
      for (int c = 0; c < exp_idx + 20; c++) begin
         @(posedge aclk);
         #1;
         if (!sync[i]) begin
            cyc = c;
            break;
         end
      end
      checkOutput("sync fall edge index after reset", cyc, exp_idx);
   endtask

   task automatic waitFrames(input int i, input int n, input int budget);
      int target = frames[i] + n;
      for (int c = 0; c < budget && frames[i] < target; c++) @(negedge aclk);
      checkOutput("frames arrived in time", frames[i] >= target, 1);
   endtask

   task automatic waitIdle(input int i, input int budget);
      for (int c = 0; c < budget && busy[i]; c++) @(negedge aclk);
      checkOutput("back to idle", busy[i], 0);
   endtask

   task automatic waitSyncLow(input int i, input int budget);
      for (int c = 0; c < budget && sync[i]; c++) @(negedge aclk);
      checkOutput("frame started", sync[i], 0);
   endtask

   initial begin
      logic [95:0] r;
      int rises;
      logic prev;
      int idle_run;
      for (int i = 0; i < 2; i++) begin
         rstn[i] = 1'b0; tvalid[i] = 1'b0; tdata[i] = '0; init_req[i] = 1'b0;
      end
      repeat (3) @(negedge aclk);
      checkReset(0);

      // Power-on init frame
      exp_q.push_back(INIT4);
      releaseAndCheckPor(0, 64);
      waitFrames(0, 1, 400);
      waitIdle(0, 50);
      checkOutput("init_done after init", done[0], 1);
      checkOutput("tready after init", tready[0], 1);

      // Two's complement extremes on the four lines
      exp_q.push_back({24'h112345, 24'h100000, 24'h180000, 24'h17FFFF});
      applyStimulus(0, {20'h12345, 20'h00000, 20'h80000, 20'h7FFFF}, 0);
      waitFrames(0, 1, 400);
      waitIdle(0, 50);

      // Three words during a running frame: only the last is sent
      r = {$urandom(), $urandom(), $urandom()};
      applyStimulus(0, r[79:0], 1);
      waitSyncLow(0, 20);
      applyStimulus(0, 80'h11111_22222_33333_44444, 0);
      applyStimulus(0, 80'h55555_66666_77777_88888, 0);
      applyStimulus(0, 80'h9ABCD_EF012_34567_89ABC, 1);
      waitFrames(0, 2, 800);
      waitIdle(0, 50);
      checkOutput("overrun_cnt after 3 accepts", ovr[0], 2);

      // Re-init requested mid-frame, queued word follows the init frame
      applyStimulus(0, 80'hFFFFF_00001_7FFFE_80001, 1);
      waitSyncLow(0, 20);
      exp_q.push_back(INIT4);
      pulseInit(0);
      applyStimulus(0, 80'h0A0A0_50505_C3C3C_3C3C3, 1);
      checkOutput("tready during re-init", tready[0], 1);
      waitFrames(0, 3, 1500);
      checkOutput("init_done during re-init", done[0], 1);
      waitIdle(0, 50);
      checkOutput("overrun_cnt unchanged", ovr[0], 2);

      // Reset asserted while bit 10 is on the wire
      applyStimulus(0, 80'h13579_2468A_BCDEF_FEDCB, 0);
      rises = 0;
      prev = sclk[0];
      for (int c = 0; c < 400 && rises < 14; c++) begin
         @(negedge aclk);
         if (!prev && sclk[0]) rises++;
         prev = sclk[0];
      end
      checkOutput("reached bit 10", rises, 14);
      rstn[0] = 1'b0;
      #1 checkReset(0);
      repeat (3) @(negedge aclk);
      exp_q.push_back(INIT4);
      releaseAndCheckPor(0, 64);
      waitFrames(0, 1, 400);
      waitIdle(0, 50);
      checkOutput("init_done after re-reset", done[0], 1);

      // CLK_DIV=1 stress; the early init_req must be absorbed by the power-on init
      @(negedge aclk);
      rstn[1] = 1'b1;
      repeat (2) @(negedge aclk);
      pulseInit(1);
      for (int c = 0; c < 200 && !done[1]; c++) @(negedge aclk);
      checkOutput("stress init_done", done[1], 1);
      for (int n = 0; n < 50; n++) begin
         @(negedge aclk);
         r = {$urandom(), $urandom(), $urandom()};
         tdata[1]  = r[79:0];
         tvalid[1] = 1'b1;
         if (tready[1]) acc_q.push_back(r[79:0]);
      end
      @(negedge aclk);
      tvalid[1] = 1'b0;
      idle_run = 0;
      for (int c = 0; c < 1000 && idle_run < 6; c++) begin
         @(negedge aclk);
         idle_run = busy[1] ? 0 : idle_run + 1;
      end
      checkOutput("stress drained", idle_run, 6);
      checkOutput("accepted = sent + overrun", data_frames[1] + ovr[1], acc_q.size());
      checkOutput("stress accepted count", acc_q.size(), 50);
      checkOutput("stress last frame is last word", last_sent, mkFrame(acc_q[acc_q.size()-1]));
      checkOutput("stress single init frame", init_frames[1], 1);

      checkOutput("sclk high with sync high (div2)", viol[0], 0);
      checkOutput("sclk high with sync high (div1)", viol[1], 0);
      checkOutput("leftover expected frames", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
